// File: rtl/arc_arrival_accum_if.sv
// arc_arrival_accum_if: arc-beat input and gate-result output handshake bundle; slack ports present under SLACK_CHECK_EN.
interface arc_arrival_accum_if #(parameter int TW = 16, parameter int PW = 3, parameter int GW = 12);
  logic          in_valid;
  logic          in_ready;
  logic [GW-1:0] in_gate;
  logic [PW-1:0] in_pin;
  logic [TW-1:0] in_arr;
  logic [TW-1:0] in_dly;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [GW-1:0] out_gate;
  logic [TW-1:0] out_arr;
  logic [PW-1:0] out_crit_pin;
  logic          out_ovf;
  logic          out_err;
`ifdef SLACK_CHECK_EN
  logic [TW-1:0] req_time;
  logic [TW:0]   out_slack;
  logic          out_viol;
`endif
  modport master (
    output in_valid, in_gate, in_pin, in_arr, in_dly, in_last, out_ready,
    input  in_ready, out_valid, out_gate, out_arr, out_crit_pin, out_ovf, out_err
`ifdef SLACK_CHECK_EN
    , output req_time, input out_slack, out_viol
`endif
  );
  modport slave (
    input  in_valid, in_gate, in_pin, in_arr, in_dly, in_last, out_ready,
    output in_ready, out_valid, out_gate, out_arr, out_crit_pin, out_ovf, out_err
`ifdef SLACK_CHECK_EN
    , input req_time, output out_slack, out_viol
`endif
  );
endinterface

// File: rtl/arc_arrival_accum.sv
// arc_arrival_accum: reduces the timing arcs of one gate output to max(arr+dly) with critical pin.
// Optional SLACK_CHECK_EN adds registered slack/violation against a required time.
module arc_arrival_accum #(
  parameter int TW = 16,
  parameter int PW = 3,
  parameter int GW = 12
) (
  input logic CP,
  input logic RST,
  arc_arrival_accum_if.slave bus
);
  typedef enum logic {FIRST, ACCUM} state_t;
  state_t        r_state;
  logic [TW-1:0] r_max;
  logic [PW-1:0] r_crit;
  logic [GW-1:0] r_gate;
  logic          r_ovf;
  logic          r_err;
  logic          r_out_valid;
  logic [TW-1:0] r_out_arr;
  logic [PW-1:0] r_out_crit;
  logic [GW-1:0] r_out_gate;
  logic          r_out_ovf;
  logic          r_out_err;
  logic [TW:0]   w_sum;
  logic          w_sat;
  logic [TW-1:0] w_clamp;
  logic          w_first;
  logic          w_take;
  logic          w_acc;
  logic [TW-1:0] w_max;
  logic [PW-1:0] w_crit;
  logic [GW-1:0] w_gate;
  logic          w_ovf;
  logic          w_err;
  assign w_sum   = {1'b0, bus.in_arr} + {1'b0, bus.in_dly};
  assign w_sat   = w_sum[TW];
  assign w_clamp = w_sat ? '1 : w_sum[TW-1:0];
  assign w_first = r_state == FIRST;
  // strict compare so a tie keeps the earlier pin
  assign w_take  = w_first | (w_clamp > r_max);
  assign w_max   = w_take ? w_clamp : r_max;
  assign w_crit  = w_take ? bus.in_pin : r_crit;
  assign w_gate  = w_first ? bus.in_gate : r_gate;
  assign w_ovf   = (w_first ? 1'b0 : r_ovf) | w_sat;
  assign w_err   = w_first ? 1'b0 : (r_err | (bus.in_gate != r_gate));
  assign bus.in_ready     = !r_out_valid | bus.out_ready;
  assign w_acc            = bus.in_valid & bus.in_ready;
  assign bus.out_valid    = r_out_valid;
  assign bus.out_arr      = r_out_arr;
  assign bus.out_crit_pin = r_out_crit;
  assign bus.out_gate     = r_out_gate;
  assign bus.out_ovf      = r_out_ovf;
  assign bus.out_err      = r_out_err;
`ifdef SLACK_CHECK_EN
  logic [TW:0] r_out_slack;
  logic        r_out_viol;
  logic [TW:0] w_slack;
  assign w_slack       = {1'b0, bus.req_time} - {1'b0, w_max};
  assign bus.out_slack = r_out_slack;
  assign bus.out_viol  = r_out_viol;
  always_ff @(posedge CP)
    if (RST) begin
      r_out_slack <= '0;
      r_out_viol  <= 1'b0;
    end else if (w_acc && bus.in_last) begin
      r_out_slack <= w_slack;
      r_out_viol  <= w_slack[TW];
    end
`endif
  always_ff @(posedge CP)
    if (RST) begin
      r_state     <= FIRST;
      r_max       <= '0;
      r_crit      <= '0;
      r_gate      <= '0;
      r_ovf       <= 1'b0;
      r_err       <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_arr   <= '0;
      r_out_crit  <= '0;
      r_out_gate  <= '0;
      r_out_ovf   <= 1'b0;
      r_out_err   <= 1'b0;
    end else begin
      if (w_acc) begin
        r_max   <= w_max;
        r_crit  <= w_crit;
        r_gate  <= w_gate;
        r_ovf   <= w_ovf;
        r_err   <= w_err;
        r_state <= bus.in_last ? FIRST : ACCUM;
      end
      // a new result may overwrite one being drained on the same edge
      if (w_acc && bus.in_last) begin
        r_out_valid <= 1'b1;
        r_out_arr   <= w_max;
        r_out_crit  <= w_crit;
        r_out_gate  <= w_gate;
        r_out_ovf   <= w_ovf;
        r_out_err   <= w_err;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
endmodule
